// File: rtl/vscale_fetch_queue_if.sv
// rtl/vscale_fetch_queue_if.sv - redirect, imem and DX-side handshake bundle for the fetch queue
//
// Signals
//   redirect, redirect_pc                      : flush request and new fetch PC from the PC mux
//   imem_req, imem_addr                        : fetch request towards instruction memory
//   imem_wait, imem_rdata, imem_badmem_e       : memory stall and the one-cycle-later response
//   out_valid, out_ready                       : handshake towards DX
//   out_pc, out_inst, out_badmem               : head entry presented to DX
// Modports
//   master : the fetch queue itself
//   slave  : the environment (PC mux, imem and DX)
interface vscale_fetch_queue_if #(
    parameter int XPR_LEN = 32
);
    logic               redirect;
    logic [XPR_LEN-1:0] redirect_pc;
    logic               imem_req;
    logic [XPR_LEN-1:0] imem_addr;
    logic               imem_wait;
    logic [XPR_LEN-1:0] imem_rdata;
    logic               imem_badmem_e;
    logic               out_valid;
    logic               out_ready;
    logic [XPR_LEN-1:0] out_pc;
    logic [XPR_LEN-1:0] out_inst;
    logic               out_badmem;

    modport master (
        input  redirect, redirect_pc,
        input  imem_wait, imem_rdata, imem_badmem_e,
        input  out_ready,
        output imem_req, imem_addr,
        output out_valid, out_pc, out_inst, out_badmem
    );

    modport slave (
        output redirect, redirect_pc,
        output imem_wait, imem_rdata, imem_badmem_e,
        output out_ready,
        input  imem_req, imem_addr,
        input  out_valid, out_pc, out_inst, out_badmem
    );
endinterface

// File: rtl/vscale_fetch_queue.sv
// rtl/vscale_fetch_queue.sv - instruction fetch queue between the PC mux and the DX stage
//
// Ports
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : vscale_fetch_queue_if.master (redirect, imem request/response, DX handshake)
// Parameters
//   XPR_LEN  : data/address width
//   DEPTH    : queue entries, power of two and at least 2
//   RESET_PC : first fetch address after reset
module vscale_fetch_queue #(
    parameter int                  XPR_LEN  = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [XPR_LEN-1:0]  RESET_PC = 'h200
) (
    input  logic                   clk,
    input  logic                   reset,
    vscale_fetch_queue_if.master   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [XPR_LEN-1:0] RV_NOP = XPR_LEN'(32'h13);

    logic [XPR_LEN-1:0] fetch_pc;
    logic [XPR_LEN-1:0] pc_mem   [DEPTH];
    logic [XPR_LEN-1:0] inst_mem [DEPTH];
    logic               bad_mem  [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               inflight;
    logic               inflight_epoch;
    logic [XPR_LEN-1:0] inflight_pc;
    logic               epoch;
    logic               fault_stop;

    logic [CNT_W:0]     occupancy;
    logic               credit_ok;
    logic               accept;
    logic               resp_enq;
    logic               deq;
    logic               head_valid;

    // The slot reserved for an outstanding request counts against the queue,
    // so a response always finds room even if DX stalls.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign credit_ok = occupancy < (CNT_W+1)'(DEPTH);

    // A redirect always requests: the flush frees every slot.
    assign bus.imem_req  = ~reset & (bus.redirect | (~fault_stop & credit_ok));
    assign bus.imem_addr = bus.redirect ? bus.redirect_pc : fetch_pc;
    assign accept        = bus.imem_req & ~bus.imem_wait;

    // Responses from an older epoch, or arriving during a redirect, belong to
    // the flushed path and are dropped.
    assign resp_enq = inflight & (inflight_epoch == epoch) & ~bus.redirect;

    // Head is driven from registered state only; imem_rdata never reaches out_*.
    assign head_valid     = ~reset & (count != '0);
    assign deq            = head_valid & bus.out_ready;
    assign bus.out_valid  = head_valid;
    assign bus.out_pc     = head_valid ? pc_mem[rd_ptr]   : '0;
    assign bus.out_inst   = head_valid ? inst_mem[rd_ptr] : RV_NOP;
    assign bus.out_badmem = head_valid & bad_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= '0;
            epoch          <= 1'b0;
            fault_stop     <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                inflight_pc <= bus.imem_addr;
                fetch_pc    <= bus.imem_addr + XPR_LEN'(4);
            end else if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
            end

            if (bus.redirect) begin
                // New epoch tags the request accepted in this same cycle.
                epoch          <= ~epoch;
                inflight_epoch <= ~epoch;
                rd_ptr         <= '0;
                wr_ptr         <= '0;
                count          <= '0;
                fault_stop     <= 1'b0;
            end else begin
                if (accept) begin
                    inflight_epoch <= epoch;
                end
                if (resp_enq) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (bus.imem_badmem_e) begin
                        fault_stop <= 1'b1;
                    end
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({resp_enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Payload storage needs no reset: entries are only read while counted.
    always_ff @(posedge clk) begin
        if (!reset && resp_enq) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            inst_mem[wr_ptr] <= bus.imem_rdata;
            bad_mem[wr_ptr]  <= bus.imem_badmem_e;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(resp_enq && !deq && count == CNT_W'(DEPTH)));
        end
    end
endmodule

// File: tb/tb_vscale_fetch_queue.sv
// tb/tb_vscale_fetch_queue.sv - directed vector bench for vscale_fetch_queue
module tb_vscale_fetch_queue;
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        bad_en;
    logic [31:0] bad_addr;
    logic [31:0] last4;
    logic [31:0] last2;
    int          checks = 0;
    int          errors = 0;

    vscale_fetch_queue_if #(.XPR_LEN(32)) bus4();
    vscale_fetch_queue_if #(.XPR_LEN(32)) bus2();

    vscale_fetch_queue #(.XPR_LEN(32), .DEPTH(4), .RESET_PC(32'h200)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );
    vscale_fetch_queue #(.XPR_LEN(32), .DEPTH(2), .RESET_PC(32'h200)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    // Memory model: answers the address presented one cycle earlier.
    always @(posedge clk) begin
        last4 <= bus4.imem_addr;
        last2 <= bus2.imem_addr;
    end
    assign bus4.imem_rdata    = last4 ^ KEY;
    assign bus4.imem_badmem_e = bad_en && (last4 == bad_addr);
    assign bus2.imem_rdata    = last2 ^ KEY;
    assign bus2.imem_badmem_e = bad_en && (last2 == bad_addr);
    assign bus2.redirect      = bus4.redirect;
    assign bus2.redirect_pc   = bus4.redirect_pc;
    assign bus2.imem_wait     = bus4.imem_wait;
    assign bus2.out_ready     = bus4.out_ready;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        wt;
        logic        rdy;
        logic        fault;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_bad;
    } row_t;
    row_t tbl[$];

    task automatic add(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic wt, input logic rdy, input logic fault,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc, input logic e_bad);
        row_t r;
        r.rst = rst; r.redir = redir; r.rpc = rpc; r.wt = wt; r.rdy = rdy; r.fault = fault;
        r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid; r.e_pc = e_pc; r.e_bad = e_bad;
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0d: got %h want %h", nm, idx, got, want);
        end
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset = 1'b1;
        bus4.redirect = 1'b0;
        bus4.redirect_pc = '0;
        bus4.imem_wait = 1'b0;
        bus4.out_ready = rdy;
        bad_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic add_reset(input logic fault);
        add(1, 0, 0, 0, 1, fault, 0, 0, 0, 0, 0);
    endtask

    // Four cycles from reset with DX stalled: 3 queued, 0x20C in flight.
    task automatic add_fill3;
        add(0, 0, 0, 0, 0, 0, 1, 'h200, 0, 0,     0);
        add(0, 0, 0, 0, 0, 0, 1, 'h204, 0, 0,     0);
        add(0, 0, 0, 0, 0, 0, 1, 'h208, 1, 'h200, 0);
        add(0, 0, 0, 0, 0, 0, 1, 'h20C, 1, 'h200, 0);
    endtask

    initial begin
        int          n;
        int          acc4;
        int          acc2;
        logic [31:0] exp_pc;

        reset = 1'b1;
        bad_en = 1'b0;
        bad_addr = 32'h208;
        bus4.redirect = 1'b0;
        bus4.redirect_pc = '0;
        bus4.imem_wait = 1'b0;
        bus4.out_ready = 1'b1;

        // rst redir rpc wt rdy fault | req addr valid pc bad
        add_reset(0); add_reset(0);
        add(0, 0, 0, 0, 1, 0, 1, 'h200, 0, 0,     0);
        add(0, 0, 0, 0, 1, 0, 1, 'h204, 0, 0,     0);
        add(0, 0, 0, 0, 1, 0, 1, 'h208, 1, 'h200, 0);
        add(0, 0, 0, 0, 1, 0, 1, 'h20C, 1, 'h204, 0);
        add(0, 0, 0, 0, 1, 0, 1, 'h210, 1, 'h208, 0);
        // reset with a response pending
        add_reset(0);
        add(0, 0, 0, 0, 1, 0, 1, 'h200, 0, 0,     0);
        add(0, 0, 0, 0, 1, 0, 1, 'h204, 0, 0,     0);
        add(0, 0, 0, 0, 1, 0, 1, 'h208, 1, 'h200, 0);
        // backpressure: exactly four requests, then drain without gaps
        add_reset(0);
        add_fill3;
        for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h200, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0,     1, 'h200, 0);
        add(0, 0, 0, 0, 1, 0, 1, 'h210, 1, 'h204, 0);
        add(0, 0, 0, 0, 1, 0, 1, 'h214, 1, 'h208, 0);
        add(0, 0, 0, 0, 1, 0, 1, 'h218, 1, 'h20C, 0);
        add(0, 0, 0, 0, 1, 0, 1, 'h21C, 1, 'h210, 0);
        // redirect with 3 queued and one in flight
        add_reset(0);
        add_fill3;
        add(0, 1, 'h1000, 0, 0, 0, 1, 'h1000, 1, 'h200,  0);
        add(0, 0, 0,      0, 1, 0, 1, 'h1004, 0, 0,      0);
        add(0, 0, 0,      0, 1, 0, 1, 'h1008, 1, 'h1000, 0);
        add(0, 0, 0,      0, 1, 0, 1, 'h100C, 1, 'h1004, 0);
        // redirect in the same cycle as a dequeue
        add_reset(0);
        add(0, 0, 0,     0, 1, 0, 1, 'h200, 0, 0,     0);
        add(0, 0, 0,     0, 1, 0, 1, 'h204, 0, 0,     0);
        add(0, 0, 0,     0, 1, 0, 1, 'h208, 1, 'h200, 0);
        add(0, 1, 'h500, 0, 1, 0, 1, 'h500, 1, 'h204, 0);
        add(0, 0, 0,     0, 1, 0, 1, 'h504, 0, 0,     0);
        add(0, 0, 0,     0, 1, 0, 1, 'h508, 1, 'h500, 0);
        // imem_wait for three cycles mid-stream
        add_reset(0);
        add(0, 0, 0, 0, 1, 0, 1, 'h200, 0, 0,     0);
        add(0, 0, 0, 0, 1, 0, 1, 'h204, 0, 0,     0);
        add(0, 0, 0, 1, 1, 0, 1, 'h208, 1, 'h200, 0);
        add(0, 0, 0, 1, 1, 0, 1, 'h208, 1, 'h204, 0);
        add(0, 0, 0, 1, 1, 0, 1, 'h208, 0, 0,     0);
        add(0, 0, 0, 0, 1, 0, 1, 'h208, 0, 0,     0);
        add(0, 0, 0, 0, 1, 0, 1, 'h20C, 0, 0,     0);
        add(0, 0, 0, 0, 1, 0, 1, 'h210, 1, 'h208, 0);
        add(0, 0, 0, 0, 1, 0, 1, 'h214, 1, 'h20C, 0);
        // access fault on 0x208 stops fetch until redirect
        add_reset(1);
        add(0, 0, 0,     0, 1, 1, 1, 'h200, 0, 0,     0);
        add(0, 0, 0,     0, 1, 1, 1, 'h204, 0, 0,     0);
        add(0, 0, 0,     0, 1, 1, 1, 'h208, 1, 'h200, 0);
        add(0, 0, 0,     0, 1, 1, 1, 'h20C, 1, 'h204, 0);
        add(0, 0, 0,     0, 1, 1, 0, 0,     1, 'h208, 1);
        add(0, 0, 0,     0, 1, 1, 0, 0,     1, 'h20C, 0);
        add(0, 0, 0,     0, 1, 1, 0, 0,     0, 0,     0);
        add(0, 0, 0,     0, 1, 1, 0, 0,     0, 0,     0);
        add(0, 1, 'h300, 0, 1, 1, 1, 'h300, 0, 0,     0);
        add(0, 0, 0,     0, 1, 1, 1, 'h304, 0, 0,     0);
        add(0, 0, 0,     0, 1, 1, 1, 'h308, 1, 'h300, 0);
        // fetch address wraps past the top of the address space
        add_reset(0);
        add(0, 1, 32'hFFFF_FFFC, 0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0,             0);
        add(0, 0, 0,             0, 1, 0, 1, 'h0,           0, 0,             0);
        add(0, 0, 0,             0, 1, 0, 1, 'h4,           1, 32'hFFFF_FFFC, 0);
        add(0, 0, 0,             0, 1, 0, 1, 'h8,           1, 'h0,           0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset            = tbl[i].rst;
            bus4.redirect    = tbl[i].redir;
            bus4.redirect_pc = tbl[i].rpc;
            bus4.imem_wait   = tbl[i].wt;
            bus4.out_ready   = tbl[i].rdy;
            bad_en           = tbl[i].fault;
            #1;
            chk("imem_req", i, {31'b0, bus4.imem_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) chk("imem_addr", i, bus4.imem_addr, tbl[i].e_addr);
            chk("out_valid", i, {31'b0, bus4.out_valid}, {31'b0, tbl[i].e_valid});
            chk("out_pc", i, bus4.out_pc, tbl[i].e_valid ? tbl[i].e_pc : 32'h0);
            chk("out_inst", i, bus4.out_inst, tbl[i].e_valid ? (tbl[i].e_pc ^ KEY) : 32'h13);
            chk("out_badmem", i, {31'b0, bus4.out_badmem}, {31'b0, tbl[i].e_bad});
        end

        // Sustained throughput: one instruction per cycle from cycle 2.
        do_reset(1'b1);
        n = 0;
        exp_pc = 32'h200;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (bus4.out_valid) begin
                chk("tput_pc", c, bus4.out_pc, exp_pc);
                exp_pc += 32'd4;
                n++;
            end
            @(negedge clk);
        end
        chk("tput_count", 0, n, 28);

        // Backpressure on both depths: credit limits outstanding work.
        do_reset(1'b0);
        acc4 = 0;
        acc2 = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus4.imem_req && !bus4.imem_wait) acc4++;
            if (bus2.imem_req && !bus2.imem_wait) acc2++;
            @(negedge clk);
        end
        chk("bp_accepts_d4", 0, acc4, 4);
        chk("bp_accepts_d2", 0, acc2, 2);
        bus4.out_ready = 1'b1;
        n = 0;
        exp_pc = 32'h200;
        for (int c = 0; c < 40 && n < 6; c++) begin
            #1;
            if (bus2.out_valid) begin
                chk("d2_pc", n, bus2.out_pc, exp_pc);
                exp_pc += 32'd4;
                n++;
            end
            @(negedge clk);
        end
        chk("d2_delivered", 0, n, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
